texture_rom_arbiter: RTL

//  Shares one synchronous texture ROM (1024 x 16-bit RGB565, ports ce/oce/reset/ad/dout)

---
 rtl/texture_rom_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/texture_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous texture ROM between two
// burst requesters; returns data tagged with requester id and last flag.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   reqN/addrN/lenN     burst request, start address, length (0 => 2**LEN_W)
//   gntN                one-cycle pulse, burst accepted
//   rvalidN, rdata      returned texel for port N
//   rlast               final word of a burst (qualified by rvalid)
//   busy                burst running or reads in flight
//   rom_ce/oce/reset/ad ROM control and address
//   rom_dout            ROM read data
module texture_rom_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 6,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [LEN_W-1:0]  len0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              rlast,
  output logic              busy,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_dout
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [LEN_W:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0] ONE_LEN  = {{LEN_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [LEN_W:0]    rem_q, rem_d;
  logic              port_q, port_d;
  logic              last_win_q, last_win_d;

  logic              pick1;
  logic [LEN_W-1:0]  len_sel;
  logic              gnt0_c, gnt1_c;
  logic              issue, issue_last;

  // return pipe: valid, port and last tags per in-flight read
  logic [ROM_LAT-1:0] pv_q, pp_q, pl_q;

  always_comb begin
    state_d    = state_q;
    ad_d       = ad_q;
    rem_d      = rem_q;
    port_d     = port_q;
    last_win_d = last_win_q;
    pick1      = 1'b0;
    len_sel    = '0;
    gnt0_c     = 1'b0;
    gnt1_c     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          // on a tie the port that did not win last time goes first
          pick1      = req1 & (~req0 | ~last_win_q);
          len_sel    = pick1 ? len1 : len0;
          port_d     = pick1;
          ad_d       = pick1 ? addr1 : addr0;
          rem_d      = (len_sel == '0) ? FULL_LEN
                                       : {1'b0, len_sel};
          last_win_d = pick1;
          gnt0_c     = ~pick1;
          gnt1_c     = pick1;
          state_d    = RUN;
        end
      end
      RUN: begin
        issue      = 1'b1;
        issue_last = (rem_q == ONE_LEN);
        rem_d      = rem_q - ONE_LEN;
        if (issue_last) begin
          // keep the final address on rom_ad while idle
          state_d = IDLE;
        end else begin
          ad_d = ad_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ad_q       <= '0;
      rem_q      <= '0;
      port_q     <= 1'b0;
      last_win_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ad_q       <= ad_d;
      rem_q      <= rem_d;
      port_q     <= port_d;
      last_win_q <= last_win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
      pp_q <= '0;
      pl_q <= '0;
    end else begin
      pv_q[0] <= issue;
      pp_q[0] <= port_q;
      pl_q[0] <= issue_last;
      for (int i = 1; i < ROM_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pp_q[i] <= pp_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
    end
  end

  logic out_v, out_p, out_l;

  assign out_v = pv_q[ROM_LAT-1];
  assign out_p = pp_q[ROM_LAT-1];
  assign out_l = pl_q[ROM_LAT-1];

  // outputs forced quiet while reset is held, so an aborted
  // burst never shows data
  assign gnt0      = gnt0_c & ~reset;
  assign gnt1      = gnt1_c & ~reset;
  assign rvalid0   = out_v & ~out_p & ~reset;
  assign rvalid1   = out_v & out_p & ~reset;
  assign rlast     = out_v & out_l & ~reset;
  assign rdata     = rom_dout;
  assign busy      = ((state_q == RUN) | (|pv_q)) & ~reset;
  assign rom_ce    = issue & ~reset;
  assign rom_oce   = 1'b1;
  assign rom_reset = reset;
  assign rom_ad    = ad_q;

endmodule
